// File: rtl/cond_unit.sv
// Execute-stage condition unit: ARM NZCV register, ARM/RISC-V condition evaluation, write/branch gating.
// Optional branch statistics counters are enabled by defining COND_UNIT_STATS_EN.
module cond_unit #(
  parameter int FLAGW = 4,
  parameter int CNTW  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             armE,
  input  logic             ValidE,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic [3:0]       CondE,
  input  logic [2:0]       Funct3E,
  input  logic             BranchE,
  input  logic [1:0]       FlagWriteE,
  input  logic             SubOpE,
  input  logic [FLAGW-1:0] ALUFlags,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  output logic             CondExE,
  output logic             PCSrcE,
  output logic             RegWriteGE,
  output logic             MemWriteGE,
  output logic [FLAGW-1:0] FlagsQ,
  output logic             CondExM,
  output logic             BranchTakenM
`ifdef COND_UNIT_STATS_EN
  , output logic [CNTW-1:0] BranchCntQ
  , output logic [CNTW-1:0] TakenCntQ
`endif
);

  logic [FLAGW-1:0] flags_r;
  logic             cond_ex_m_r;
  logic             branch_taken_m_r;
  logic             arm_cond_s;
  logic             rv_cond_s;
  logic             cond_ex_s;
  logic             pc_src_s;
  logic             flag_upd_s;
  logic             n_s, z_s, c_s, v_s;

  assign n_s = flags_r[3];
  assign z_s = flags_r[2];
  assign c_s = flags_r[1];
  assign v_s = flags_r[0];

  // ARM condition evaluated against the architectural (registered) flags
  always_comb begin
    arm_cond_s = 1'b0;
    case (CondE)
      4'b0000: arm_cond_s = z_s;
      4'b0001: arm_cond_s = ~z_s;
      4'b0010: arm_cond_s = c_s;
      4'b0011: arm_cond_s = ~c_s;
      4'b0100: arm_cond_s = n_s;
      4'b0101: arm_cond_s = ~n_s;
      4'b0110: arm_cond_s = v_s;
      4'b0111: arm_cond_s = ~v_s;
      4'b1000: arm_cond_s = c_s & ~z_s;
      4'b1001: arm_cond_s = ~c_s | z_s;
      4'b1010: arm_cond_s = (n_s == v_s);
      4'b1011: arm_cond_s = (n_s != v_s);
      4'b1100: arm_cond_s = ~z_s & (n_s == v_s);
      4'b1101: arm_cond_s = z_s | (n_s != v_s);
      4'b1110: arm_cond_s = 1'b1;
      default: arm_cond_s = 1'b0;
    endcase
  end

  // RISC-V branch condition from the raw ALU flags (C = borrow)
  always_comb begin
    rv_cond_s = 1'b0;
    case (Funct3E)
      3'b000:  rv_cond_s = ALUFlags[2];
      3'b001:  rv_cond_s = ~ALUFlags[2];
      3'b100:  rv_cond_s = (ALUFlags[3] != ALUFlags[0]);
      3'b101:  rv_cond_s = (ALUFlags[3] == ALUFlags[0]);
      3'b110:  rv_cond_s = ALUFlags[1];
      3'b111:  rv_cond_s = ~ALUFlags[1];
      default: rv_cond_s = 1'b0;
    endcase
  end

  // Select ISA, then kill bubbles and flushed instructions
  always_comb begin
    cond_ex_s = 1'b0;
    if (!ValidE || FlushE) begin
      cond_ex_s = 1'b0;
    end else if (armE) begin
      cond_ex_s = arm_cond_s;
    end else if (BranchE) begin
      cond_ex_s = rv_cond_s;
    end else begin
      cond_ex_s = 1'b1;
    end
  end

  assign pc_src_s   = BranchE & cond_ex_s;
  assign flag_upd_s = armE & cond_ex_s & ~StallE;

  assign CondExE    = cond_ex_s;
  assign PCSrcE     = pc_src_s;
  assign RegWriteGE = RegWriteE & cond_ex_s;
  assign MemWriteGE = MemWriteE & cond_ex_s;

  // NZCV register; ARM stores carry as "no borrow", hence the SubOpE inversion
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_r <= {FLAGW{1'b0}};
    end else if (flag_upd_s) begin
      if (FlagWriteE[1]) flags_r[3:2] <= ALUFlags[3:2];
      if (FlagWriteE[0]) flags_r[1:0] <= {ALUFlags[1] ^ SubOpE, ALUFlags[0]};
    end
  end

  // M-stage condition registers; a flush under stall waits for the stall to drop
  always_ff @(posedge clk) begin
    if (reset) begin
      cond_ex_m_r      <= 1'b0;
      branch_taken_m_r <= 1'b0;
    end else if (!StallE) begin
      if (FlushE) begin
        cond_ex_m_r      <= 1'b0;
        branch_taken_m_r <= 1'b0;
      end else begin
        cond_ex_m_r      <= cond_ex_s;
        branch_taken_m_r <= pc_src_s;
      end
    end
  end

  assign FlagsQ       = flags_r;
  assign CondExM      = cond_ex_m_r;
  assign BranchTakenM = branch_taken_m_r;

`ifdef COND_UNIT_STATS_EN
  logic [CNTW-1:0] branch_cnt_r;
  logic [CNTW-1:0] taken_cnt_r;
  logic            br_retire_s;

  assign br_retire_s = BranchE & ValidE & ~FlushE & ~StallE;

  // Saturating branch statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt_r <= {CNTW{1'b0}};
      taken_cnt_r  <= {CNTW{1'b0}};
    end else if (br_retire_s) begin
      if (branch_cnt_r != {CNTW{1'b1}})
        branch_cnt_r <= branch_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
      if (pc_src_s && (taken_cnt_r != {CNTW{1'b1}}))
        taken_cnt_r <= taken_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  assign BranchCntQ = branch_cnt_r;
  assign TakenCntQ  = taken_cnt_r;
`endif

endmodule
